// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester handshake and memory-pin bundle for mem_arbiter
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic        lock0;
    logic        lock1;
    logic        ack0;
    logic        ack1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, grant, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we, grant, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with burst lock and wait-state sequencing
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_LOCK    = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_ptr;
    logic        r_lock_vld;
    logic        r_lock_own;
    logic [7:0]  r_lock_cnt;
    logic        r_own;
    logic        r_lock_req;
    logic        r_via_lock;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic        r_ack0;
    logic        r_ack1;
    logic [15:0] r_rdata0;
    logic [15:0] r_rdata1;
    logic [1:0]  r_grant;
    logic        r_busy;

    logic [1:0]  w_req;
    logic        w_lock_win;
    logic        w_win;
    logic [7:0]  w_lock_cnt_nxt;

    assign w_req      = {bus.req1, bus.req0};
    assign w_lock_win = r_lock_vld && w_req[r_lock_own] && (r_lock_cnt < LP_MAX_LOCK);

    always_comb begin
        w_win = r_ptr;
        if (w_lock_win) begin
            w_win = r_lock_own;
        end else if (w_req[0] != w_req[1]) begin
            w_win = w_req[1];
        end
    end

    // A lock taken by a rotation win starts fresh; only lock-driven wins count toward the limit.
    assign w_lock_cnt_nxt = r_via_lock ? 8'(r_lock_cnt + 8'd1) : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_ptr      <= 1'b0;
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_own      <= 1'b0;
            r_lock_req <= 1'b0;
            r_via_lock <= 1'b0;
            r_addr     <= 8'd0;
            r_wdata    <= 8'd0;
            r_we       <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= 16'd0;
            r_rdata1   <= 16'd0;
            r_grant    <= 2'b00;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_lock_vld && !w_req[r_lock_own]) begin
                        r_lock_vld <= 1'b0;
                        r_lock_cnt <= 8'd0;
                    end
                    if (|w_req) begin
                        r_own      <= w_win;
                        r_addr     <= w_win ? bus.addr1  : bus.addr0;
                        r_wdata    <= w_win ? bus.wdata1 : bus.wdata0;
                        r_we       <= w_win ? bus.we1    : bus.we0;
                        r_lock_req <= w_win ? bus.lock1  : bus.lock0;
                        r_via_lock <= w_lock_win;
                        r_grant    <= w_win ? 2'b10 : 2'b01;
                        r_ptr      <= ~w_win;
                        r_cnt      <= LP_CNT_LOAD;
                        r_busy     <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_own) begin
                                r_rdata1 <= bus.mem_rdata;
                            end else begin
                                r_rdata0 <= bus.mem_rdata;
                            end
                        end
                        if (r_own) begin
                            r_ack1 <= 1'b1;
                        end else begin
                            r_ack0 <= 1'b1;
                        end
                        r_grant <= 2'b00;
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (r_lock_req && (w_lock_cnt_nxt < LP_MAX_LOCK)) begin
                        r_lock_vld <= 1'b1;
                        r_lock_own <= r_own;
                        r_lock_cnt <= w_lock_cnt_nxt;
                    end else begin
                        r_lock_vld <= 1'b0;
                        r_lock_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write strobe is decoded from reset-cleared state so it falls the moment rst rises.
    assign bus.mem_we    = (r_state == S_ACCESS) && r_we && (r_cnt == 4'd0);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if b1();
    mem_arbiter_if b3();
    mem_arbiter_if b4();

    mem_arbiter #(.WAIT_CYCLES(1), .MAX_LOCK(2))  dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.WAIT_CYCLES(3), .MAX_LOCK(16)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    mem_arbiter #(.WAIT_CYCLES(4), .MAX_LOCK(16)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return 16'h8402 ^ {a, a};
    endfunction

    // Memories hold a delta over init_word so they start from known content.
    bit [15:0] m1[256];
    bit [15:0] m3[256];
    bit [15:0] m4[256];
    assign b1.mem_rdata = init_word(b1.mem_addr) ^ m1[b1.mem_addr];
    assign b3.mem_rdata = init_word(b3.mem_addr) ^ m3[b3.mem_addr];
    assign b4.mem_rdata = init_word(b4.mem_addr) ^ m4[b4.mem_addr];
    always @(posedge clk) begin
        if (b1.mem_we) m1[b1.mem_addr] <= {b1.mem_wdata, b1.mem_wdata} ^ init_word(b1.mem_addr);
        if (b3.mem_we) m3[b3.mem_addr] <= {b3.mem_wdata, b3.mem_wdata} ^ init_word(b3.mem_addr);
        if (b4.mem_we) m4[b4.mem_addr] <= {b4.mem_wdata, b4.mem_wdata} ^ init_word(b4.mem_addr);
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] e1[256];
    vec_t        vecs[7];
    logic [1:0]  gq[$];
    int          tq[$];
    logic [1:0]  aq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic p, input logic req, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic lock);
        if (p == 1'b0) begin
            b1.req0 = req; b1.we0 = we; b1.addr0 = addr; b1.wdata0 = wdata; b1.lock0 = lock;
        end else begin
            b1.req1 = req; b1.we1 = we; b1.addr1 = addr; b1.wdata1 = wdata; b1.lock1 = lock;
        end
    endtask

    task automatic clear_inputs;
        drive1(1'b0, 0, 0, 8'h00, 8'h00, 0);
        drive1(1'b1, 0, 0, 8'h00, 8'h00, 0);
        b3.req0 = 0; b3.we0 = 0; b3.addr0 = 0; b3.wdata0 = 0; b3.lock0 = 0;
        b3.req1 = 0; b3.we1 = 0; b3.addr1 = 0; b3.wdata1 = 0; b3.lock1 = 0;
        b4.req0 = 0; b4.we0 = 0; b4.addr0 = 0; b4.wdata0 = 0; b4.lock0 = 0;
        b4.req1 = 0; b4.we1 = 0; b4.addr1 = 0; b4.wdata1 = 0; b4.lock1 = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic apply_vec(input vec_t v);
        logic [1:0] oh;
        oh = v.port ? 2'b10 : 2'b01;
        drive1(v.port, 1, v.we, v.addr, v.wdata, 0);
        tick();
        chk("vec_grant",  b1.grant, oh);
        chk("vec_maddr",  b1.mem_addr, v.addr);
        chk("vec_mem_we", b1.mem_we, v.we);
        chk("vec_early_ack", {b1.ack1, b1.ack0}, 2'b00);
        tick();
        chk("vec_ack", {b1.ack1, b1.ack0}, oh);
        chk("vec_grant_ack", b1.grant, 2'b00);
        chk("vec_rdata", v.port ? b1.rdata1 : b1.rdata0, v.exp_rdata);
        if (v.we) e1[v.addr] = {v.wdata, v.wdata};
        drive1(v.port, 0, 0, 8'h00, 8'h00, 0);
        tick();
        chk("vec_ack_drop", {b1.ack1, b1.ack0, b1.busy}, 3'b000);
    endtask

    // Arbitration reference, reasoned per transaction from the rules, not per cycle.
    task automatic random_test(input int n);
        logic        act[2], pwe[2], plk[2];
        logic [7:0]  pad[2], pwd[2];
        logic [15:0] rd_exp[2];
        logic        ptr, lk_vld, lk_own, via, w, got, gseen;
        int          lk_cnt, wecnt;
        ptr = 0; lk_vld = 0; lk_own = 0; lk_cnt = 0;
        rd_exp[0] = 16'h0; rd_exp[1] = 16'h0;
        act[0] = 0; act[1] = 0;
        for (int i = 0; i < 2; i++) begin
            pwe[i] = 0; plk[i] = 0; pad[i] = 0; pwd[i] = 0;
        end
        for (int t = 0; t < n; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && ($urandom_range(0, 1) == 1)) begin
                    act[p] = 1; pwe[p] = 1'($urandom_range(0, 1)); pad[p] = 8'($urandom_range(0, 15));
                    pwd[p] = 8'($urandom); plk[p] = ($urandom_range(0, 3) == 0);
                end
            end
            if (!act[0] && !act[1]) begin
                w = 1'($urandom_range(0, 1));
                act[w] = 1; pwe[w] = 0; pad[w] = 8'($urandom_range(0, 15)); pwd[w] = 8'h00; plk[w] = 0;
            end
            for (int p = 0; p < 2; p++) drive1(1'(p), act[p], pwe[p], pad[p], pwd[p], plk[p]);
            if (lk_vld && !act[lk_own]) begin lk_vld = 0; lk_cnt = 0; end
            via = lk_vld && act[lk_own] && (lk_cnt < 2);
            if (via) w = lk_own;
            else if (act[0] != act[1]) w = act[1];
            else w = ptr;
            ptr = ~w;
            got = 0; gseen = 0; wecnt = 0;
            for (int k = 0; k < 8 && !got; k++) begin
                tick();
                if (b1.grant != 2'b00 && !gseen) begin
                    gseen = 1;
                    chk("rnd_grant", b1.grant, w ? 2'b10 : 2'b01);
                end
                if (b1.mem_we) begin
                    wecnt++;
                    chk("rnd_we_addr", b1.mem_addr, pad[w]);
                end
                if (b1.ack0 || b1.ack1) got = 1;
            end
            chk("rnd_grant_seen", gseen, 1);
            chk("rnd_ack", {b1.ack1, b1.ack0}, w ? 2'b10 : 2'b01);
            if (pwe[w]) e1[pad[w]] = {pwd[w], pwd[w]};
            else rd_exp[w] = e1[pad[w]];
            chk("rnd_rdata0", b1.rdata0, rd_exp[0]);
            chk("rnd_rdata1", b1.rdata1, rd_exp[1]);
            chk("rnd_we_count", wecnt, pwe[w] ? 1 : 0);
            if (plk[w]) begin
                lk_cnt = via ? lk_cnt + 1 : 0;
                lk_vld = 1; lk_own = w;
                if (lk_cnt >= 2) begin lk_vld = 0; lk_cnt = 0; end
            end else begin
                lk_vld = 0; lk_cnt = 0;
            end
            act[w] = 0;
            drive1(w, 0, 0, 8'h00, 8'h00, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] prevg;
        int         gcnt, acnt;
        for (int i = 0; i < 256; i++) e1[i] = init_word(8'(i));
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h8402};
        vecs[1] = '{1'b1, 1'b0, 8'h05, 8'h00, 16'h8107};
        vecs[2] = '{1'b1, 1'b1, 8'h22, 8'h3C, 16'h8107};
        vecs[3] = '{1'b0, 1'b0, 8'h22, 8'h00, 16'h3C3C};
        vecs[4] = '{1'b0, 1'b1, 8'h05, 8'hA7, 16'h3C3C};
        vecs[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 16'hA7A7};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 16'h7BFD};

        do_reset();
        chk("reset_state_w1", {b1.ack0, b1.ack1, b1.rdata0, b1.rdata1, b1.mem_addr, b1.mem_wdata,
                               b1.mem_we, b1.grant, b1.busy}, 64'h0);
        chk("reset_state_w4", {b4.ack0, b4.ack1, b4.rdata0, b4.rdata1, b4.mem_addr, b4.mem_wdata,
                               b4.mem_we, b4.grant, b4.busy}, 64'h0);

        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // Contention: both ports always requesting.
        do_reset();
        drive1(1'b0, 1, 0, 8'h01, 8'h00, 0);
        drive1(1'b1, 1, 0, 8'h02, 8'h00, 0);
        gq.delete(); tq.delete(); aq.delete();
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (b1.grant != 2'b00) gq.push_back(b1.grant);
            if (b1.ack0 || b1.ack1) begin tq.push_back(c); aq.push_back({b1.ack1, b1.ack0}); end
        end
        clear_inputs();
        chk("cont_grant_count", gq.size() >= 4, 1);
        for (int i = 0; i < 4; i++)
            chk("cont_grant_order", (i < gq.size()) ? gq[i] : 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);
        chk("cont_ack_count", tq.size(), 5);
        for (int i = 0; i < 4; i++)
            chk("cont_ack_spacing", (i + 1 < tq.size()) ? tq[i+1] - tq[i] : 0, 3);
        for (int i = 0; i < 2; i++)
            chk("cont_ack_port", (i < aq.size()) ? aq[i] : 2'b00, (i == 0) ? 2'b01 : 2'b10);

        // Lock burst, MAX_LOCK=2.
        do_reset();
        drive1(1'b0, 1, 0, 8'h03, 8'h00, 1);
        drive1(1'b1, 1, 0, 8'h04, 8'h00, 0);
        gq.delete();
        prevg = 2'b00;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (b1.grant != 2'b00 && prevg == 2'b00) gq.push_back(b1.grant);
            prevg = b1.grant;
        end
        clear_inputs();
        for (int i = 0; i < 4; i++)
            chk("lock_grant_order", (i < gq.size()) ? gq[i] : 2'b00, (i < 3) ? 2'b01 : 2'b10);

        // Stale request held through the ack cycle.
        do_reset();
        drive1(1'b0, 1, 0, 8'h00, 8'h00, 0);
        tick();
        tick();
        chk("stale_first_ack", b1.ack0, 1);
        tick();
        drive1(1'b0, 0, 0, 8'h00, 8'h00, 0);
        gcnt = 0; acnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b1.grant != 2'b00) gcnt++;
            if (b1.ack0 || b1.ack1) acnt++;
        end
        chk("stale_no_regrant", gcnt, 0);
        chk("stale_no_reack", acnt, 0);

        // Write with WAIT_CYCLES=3; rdata1 must survive the write.
        do_reset();
        b3.req1 = 1; b3.we1 = 0; b3.addr1 = 8'h11;
        for (int k = 0; k < 10 && !b3.ack1; k++) tick();
        chk("w3_read_ack", b3.ack1, 1);
        chk("w3_read_data", b3.rdata1, 16'h9513);
        b3.req1 = 0;
        tick();
        b3.req1 = 1; b3.we1 = 1; b3.addr1 = 8'h10; b3.wdata1 = 8'h5A;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("w3_mem_addr", b3.mem_addr, 8'h10);
            chk("w3_grant", b3.grant, 2'b10);
            chk("w3_mem_we", b3.mem_we, (c == 3) ? 1 : 0);
            chk("w3_no_ack", b3.ack1, 0);
        end
        tick();
        chk("w3_ack", {b3.ack1, b3.ack0, b3.mem_we}, 3'b100);
        chk("w3_rdata_kept", b3.rdata1, 16'h9513);
        b3.req1 = 0; b3.we1 = 0;
        tick();
        chk("w3_ack_pulse", b3.ack1, 0);
        b3.req1 = 1; b3.addr1 = 8'h10;
        for (int k = 0; k < 10 && !b3.ack1; k++) tick();
        chk("w3_readback", b3.rdata1, 16'h5A5A);
        b3.req1 = 0;
        tick();

        // Reset during a WAIT_CYCLES=4 write, then re-arbitration.
        do_reset();
        b4.req0 = 1; b4.we0 = 1; b4.addr0 = 8'h33; b4.wdata0 = 8'hC1;
        tick();
        tick();
        chk("rst_pre_grant", {b4.grant, b4.busy}, 3'b011);
        rst = 1'b1;
        #1;
        chk("rst_async_out", {b4.mem_we, b4.grant, b4.busy, b4.ack0}, 5'b0);
        tick();
        chk("rst_no_ack_a", b4.ack0, 0);
        tick();
        chk("rst_no_ack_b", b4.ack0, 0);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("rst_restart_grant", b4.grant, 2'b01);
            chk("rst_restart_we", b4.mem_we, (c == 4) ? 1 : 0);
        end
        tick();
        chk("rst_restart_ack", b4.ack0, 1);
        b4.req0 = 0;
        tick();
        b4.req0 = 1; b4.we0 = 1; b4.addr0 = 8'h34; b4.wdata0 = 8'h77;
        repeat (4) tick();
        chk("rst_we_before", b4.mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_we_async_drop", {b4.mem_we, b4.busy}, 2'b00);
        b4.req0 = 0;
        tick();
        chk("rst_write_discarded", m4[8'h34], 16'h0);
        rst = 1'b0;
        tick();

        do_reset();
        random_test(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
